// File: rtl/bet_executor_if.sv
// bet_executor_if: action handshake between an action source (master) and bet_executor (slave)
// Signals: act_valid/act_seat/action from the source; act_ready/act_done/illegal back from the executor.
interface bet_executor_if;
  logic       act_valid;
  logic       act_seat;
  logic [2:0] action;
  logic       act_ready;
  logic       act_done;
  logic       illegal;
  modport master (output act_valid, act_seat, action, input act_ready, act_done, illegal);
  modport slave (input act_valid, act_seat, action, output act_ready, act_done, illegal);
endinterface

// File: rtl/bet_executor.sv
// bet_executor: applies 3-bit seat actions (check/call/raise/all-in/fold) to stacks, street bets and pot
// Ports: clk, resetn (sync active-low); new_game, post_blinds, sb_is_cpu, new_street commands;
//   bus (slave): act_valid/act_seat/action in, act_ready/act_done/illegal out;
//   player_money, cpu_money, player_bet, cpu_bet, pot, folded, fold_seat, round_over out.
// Optional: define BET_EXEC_ACTCNT_EN to add act_count (legal actions this street, saturating at 15).
module bet_executor #(
  parameter int MW         = 15,
  parameter int SB         = 100,
  parameter int BB         = 200,
  parameter int INIT_STACK = 2000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          new_game,
  input  logic          post_blinds,
  input  logic          sb_is_cpu,
  input  logic          new_street,
  bet_executor_if.slave bus,
  output logic [MW-1:0] player_money,
  output logic [MW-1:0] cpu_money,
  output logic [MW-1:0] player_bet,
  output logic [MW-1:0] cpu_bet,
  output logic [MW:0]   pot,
  output logic          folded,
  output logic          fold_seat,
  output logic          round_over
`ifdef BET_EXEC_ACTCNT_EN
  ,
  output logic [3:0]    act_count
`endif
);
  typedef enum logic [1:0] {IDLE, EVAL, XFER, DONE} state_t;
  state_t state;
  logic seat, legal, acted_p, acted_c, is_raise, e_legal, na_p, na_c, ro;
  logic [2:0] act;
  logic [MW-1:0] amt, own, opp, m, nbb, gap, e_amt, nown, nm;
  logic [MW-1:0] nb_p, nb_c, nm_p, nm_c, p_need, c_need, p_due, c_due;
  assign bus.act_ready = state == IDLE;
  assign own = seat ? cpu_bet : player_bet;
  assign opp = seat ? player_bet : cpu_bet;
  assign m = seat ? cpu_money : player_money;
  assign gap = opp - own;
  assign is_raise = act inside {3'd2, 3'd3, 3'd4};
  assign nbb = act == 3'd2 ? MW'(2 * BB) : act == 3'd3 ? MW'(4 * BB) : MW'(6 * BB);
  // nbb > own keeps nbb - own from wrapping when the actor is already ahead
  assign e_legal = act == 3'd0 ? own == opp :
                   act == 3'd1 ? opp > own :
                   is_raise    ? nbb > opp && nbb > own && m > nbb - own :
                   act == 3'd5 ? m != '0 : act == 3'd6;
  assign e_amt = act == 3'd1 ? (gap < m ? gap : m) : is_raise ? nbb - own : act == 3'd5 ? m : '0;
  // post-transfer view used to decide whether the street closes
  assign nown = own + amt;
  assign nm = m - amt;
  assign nb_p = seat ? player_bet : nown;
  assign nb_c = seat ? nown : cpu_bet;
  assign nm_p = seat ? player_money : nm;
  assign nm_c = seat ? nm : cpu_money;
  assign na_p = seat ? acted_p && nown <= opp : 1'b1;
  assign na_c = seat ? 1'b1 : acted_c && nown <= opp;
  assign ro = (nb_p == nb_c && na_p && na_c) ||
              (nm_p == '0 && ((na_c && nb_c >= nb_p) || nm_c == '0)) ||
              (nm_c == '0 && ((na_p && nb_p >= nb_c) || nm_p == '0));
  assign p_need = sb_is_cpu ? MW'(BB) : MW'(SB);
  assign c_need = sb_is_cpu ? MW'(SB) : MW'(BB);
  assign p_due = player_money < p_need ? player_money : p_need;
  assign c_due = cpu_money < c_need ? cpu_money : c_need;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      seat <= 1'b0;
      act <= '0;
      amt <= '0;
      legal <= 1'b0;
      acted_p <= 1'b0;
      acted_c <= 1'b0;
      player_money <= '0;
      cpu_money <= '0;
      player_bet <= '0;
      cpu_bet <= '0;
      pot <= '0;
      folded <= 1'b0;
      fold_seat <= 1'b0;
      round_over <= 1'b0;
      bus.act_done <= 1'b0;
      bus.illegal <= 1'b0;
`ifdef BET_EXEC_ACTCNT_EN
      act_count <= '0;
`endif
    end else begin
      bus.act_done <= 1'b0;
      case (state)
        IDLE: begin
          if (new_game) begin
            player_money <= MW'(INIT_STACK);
            cpu_money <= MW'(INIT_STACK);
            player_bet <= '0;
            cpu_bet <= '0;
            pot <= '0;
            acted_p <= 1'b0;
            acted_c <= 1'b0;
            folded <= 1'b0;
            fold_seat <= 1'b0;
            round_over <= 1'b0;
`ifdef BET_EXEC_ACTCNT_EN
            act_count <= '0;
`endif
          end else if (post_blinds) begin
            player_money <= player_money - p_due;
            cpu_money <= cpu_money - c_due;
            player_bet <= p_due;
            cpu_bet <= c_due;
            pot <= '0;
            acted_p <= 1'b0;
            acted_c <= 1'b0;
            folded <= 1'b0;
            round_over <= 1'b0;
`ifdef BET_EXEC_ACTCNT_EN
            act_count <= '0;
`endif
          end else if (new_street) begin
            pot <= pot + {1'b0, player_bet} + {1'b0, cpu_bet};
            player_bet <= '0;
            cpu_bet <= '0;
            acted_p <= 1'b0;
            acted_c <= 1'b0;
            round_over <= 1'b0;
`ifdef BET_EXEC_ACTCNT_EN
            act_count <= '0;
`endif
          end else if (bus.act_valid) begin
            seat <= bus.act_seat;
            act <= bus.action;
            if (folded || round_over) begin
              bus.illegal <= 1'b1;
              bus.act_done <= 1'b1;
              state <= DONE;
            end else state <= EVAL;
          end
        end
        EVAL: begin
          legal <= e_legal;
          amt <= e_amt;
          state <= XFER;
        end
        XFER: begin
          if (legal && act == 3'd6) begin
            folded <= 1'b1;
            fold_seat <= seat;
            round_over <= 1'b1;
          end else if (legal) begin
            if (seat) begin
              cpu_money <= nm;
              cpu_bet <= nown;
              acted_c <= 1'b1;
              acted_p <= na_p;
            end else begin
              player_money <= nm;
              player_bet <= nown;
              acted_p <= 1'b1;
              acted_c <= na_c;
            end
            round_over <= ro;
          end
`ifdef BET_EXEC_ACTCNT_EN
          if (legal && act_count != 4'hf) act_count <= act_count + 4'd1;
`endif
          bus.illegal <= !legal;
          bus.act_done <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bet_executor.sv
// tb_bet_executor: scoreboard bench for bet_executor with directed hand-computed action vectors
module tb_bet_executor;
  logic clk = 1'b0, resetn = 1'b0, new_game = 1'b0, post_blinds = 1'b0, sb_is_cpu = 1'b0, new_street = 1'b0;
  logic [14:0] player_money, cpu_money, player_bet, cpu_bet;
  logic [15:0] pot;
  logic folded, fold_seat, round_over;
`ifdef BET_EXEC_ACTCNT_EN
  logic [3:0] act_count;
`endif
  typedef struct {int il, pm, cm, pb, cb, pt, fo, fs, ro, lat;} exp_t;
  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0, cyc = 0, hs = 0, done_cnt = 0;
  bet_executor_if bus();
  bet_executor dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .post_blinds(post_blinds),
    .sb_is_cpu(sb_is_cpu), .new_street(new_street), .bus(bus),
    .player_money(player_money), .cpu_money(cpu_money), .player_bet(player_bet),
    .cpu_bet(cpu_bet), .pot(pot), .folded(folded), .fold_seat(fold_seat), .round_over(round_over)
`ifdef BET_EXEC_ACTCNT_EN
    , .act_count(act_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  function automatic exp_t ex(input int il, pm, cm, pb, cb, pt, fo, fs, ro, lat);
    exp_t e;
    e.il = il; e.pm = pm; e.cm = cm; e.pb = pb; e.cb = cb; e.pt = pt;
    e.fo = fo; e.fs = fs; e.ro = ro; e.lat = lat;
    return e;
  endfunction
  always @(negedge clk) begin
    if (bus.act_done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_act_done: got act_done=1, expected no response");
      end else begin
        me = q.pop_front();
        chk("illegal", int'(bus.illegal), me.il);
        chk("player_money", int'(player_money), me.pm);
        chk("cpu_money", int'(cpu_money), me.cm);
        chk("player_bet", int'(player_bet), me.pb);
        chk("cpu_bet", int'(cpu_bet), me.cb);
        chk("pot", int'(pot), me.pt);
        chk("folded", int'(folded), me.fo);
        chk("fold_seat", int'(fold_seat), me.fs);
        chk("round_over", int'(round_over), me.ro);
        chk("latency", cyc - hs, me.lat);
      end
      done_cnt++;
    end
  end
  task automatic cmd(input logic ng, input logic pb, input logic sbc, input logic ns);
    @(negedge clk);
    new_game = ng; post_blinds = pb; sb_is_cpu = sbc; new_street = ns;
    @(negedge clk);
    new_game = 1'b0; post_blinds = 1'b0; new_street = 1'b0;
  endtask
  task automatic chk_regs(input int pm, cm, pb, cb, pt);
    chk("reg_player_money", int'(player_money), pm);
    chk("reg_cpu_money", int'(cpu_money), cm);
    chk("reg_player_bet", int'(player_bet), pb);
    chk("reg_cpu_bet", int'(cpu_bet), cb);
    chk("reg_pot", int'(pot), pt);
  endtask
  task automatic do_act(input logic s, input logic [2:0] c, input exp_t e);
    int n, d0;
    q.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    bus.act_valid = 1'b1; bus.act_seat = s; bus.action = c;
    n = 0;
    while (bus.act_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    hs = cyc;
    @(posedge clk);
    #1 bus.act_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin @(posedge clk); n++; end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL act_done_timeout: got no act_done in 20 cycles, expected one");
      q.delete();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    bus.act_valid = 1'b0; bus.act_seat = 1'b0; bus.action = 3'd0;
    repeat (3) @(negedge clk);
    chk_regs(0, 0, 0, 0, 0);
    chk("reset_act_ready", int'(bus.act_ready), 1);
    chk("reset_act_done", int'(bus.act_done), 0);
    chk("reset_round_over", int'(round_over), 0);
    resetn = 1'b1;
    // hand 1: preflop call/check, then raise/re-raise/call
    cmd(1, 0, 0, 0);
    chk_regs(2000, 2000, 0, 0, 0);
    cmd(0, 1, 1, 0);
    chk_regs(1800, 1900, 200, 100, 0);
    do_act(1, 3'd1, ex(0, 1800, 1800, 200, 200, 0, 0, 0, 0, 3));
    do_act(0, 3'd0, ex(0, 1800, 1800, 200, 200, 0, 0, 0, 1, 3));
    do_act(1, 3'd0, ex(1, 1800, 1800, 200, 200, 0, 0, 0, 1, 1));
    cmd(0, 0, 0, 1);
    chk_regs(1800, 1800, 0, 0, 400);
    do_act(1, 3'd2, ex(0, 1800, 1400, 0, 400, 400, 0, 0, 0, 3));
    do_act(0, 3'd0, ex(1, 1800, 1400, 0, 400, 400, 0, 0, 0, 3));
    do_act(0, 3'd7, ex(1, 1800, 1400, 0, 400, 400, 0, 0, 0, 3));
    do_act(0, 3'd3, ex(0, 1000, 1400, 800, 400, 400, 0, 0, 0, 3));
    do_act(1, 3'd1, ex(0, 1000, 1000, 800, 800, 400, 0, 0, 1, 3));
    // hand 2: drain player stack to 300 with repeated blinds, then short all-in call
    cmd(1, 0, 0, 0);
    cmd(0, 1, 0, 0);
    chk_regs(1900, 1800, 100, 200, 0);
    for (int i = 0; i < 8; i++) cmd(0, 1, 1, 0);
    cmd(0, 0, 0, 1);
    chk_regs(300, 1000, 0, 0, 300);
    do_act(1, 3'd3, ex(0, 300, 200, 0, 800, 300, 0, 0, 0, 3));
    do_act(0, 3'd1, ex(0, 0, 200, 300, 800, 300, 0, 0, 1, 3));
    cmd(0, 0, 0, 1);
    chk_regs(0, 200, 0, 0, 1400);
    do_act(1, 3'd6, ex(0, 0, 200, 0, 0, 1400, 1, 1, 1, 3));
    do_act(0, 3'd1, ex(1, 0, 200, 0, 0, 1400, 1, 1, 1, 1));
    // blinds capped by short stacks, and folded/round_over cleared
    cmd(0, 1, 1, 0);
    chk_regs(0, 100, 0, 100, 0);
    chk("blinds_folded", int'(folded), 0);
    chk("blinds_round_over", int'(round_over), 0);
    // reset while the action is in XFER: no partial update
    cmd(1, 0, 0, 0);
    cmd(0, 1, 1, 0);
    d0 = done_cnt;
    @(negedge clk);
    bus.act_valid = 1'b1; bus.act_seat = 1'b1; bus.action = 3'd1;
    @(posedge clk);
    #1 bus.act_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_regs(0, 0, 0, 0, 0);
    chk("xfer_reset_act_ready", int'(bus.act_ready), 1);
    chk("xfer_reset_act_done", int'(bus.act_done), 0);
    chk("xfer_reset_folded", int'(folded), 0);
    chk("xfer_reset_round_over", int'(round_over), 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("xfer_reset_no_done", done_cnt, d0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
